// File: rtl/store_commit_queue.sv
// In-order store drain queue: holds resolved stores until ROB commit, then writes
// them to memory one at a time; rollback discards the uncommitted tail.
module store_commit_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rollback_in,
   input  logic                 push_in,
   input  logic [TAG_WIDTH-1:0] push_tag_in,
   input  logic [31:0]          push_addr_in,
   input  logic [31:0]          push_data_in,
   input  logic [1:0]           push_size_in,
   input  logic                 commit_lsb_signal_in,
   input  logic [TAG_WIDTH-1:0] commit_tag_in,
   input  logic [31:0]          ld_addr_in,
   output logic                 hazard_out,
   output logic                 full_out,
   output logic                 idle_out,
   output logic                 mem_req_out,
   output logic [31:0]          mem_addr_out,
   output logic [31:0]          mem_data_out,
   output logic [1:0]           mem_size_out,
   input  logic                 mem_done_in
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_MEM = 1'b1;

   typedef struct packed {
      logic [TAG_WIDTH-1:0] tag;
      logic [31:0]          addr;
      logic [31:0]          data;
      logic [1:0]           size;
   } entry_t;

   entry_t           ent [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] committed;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [DEPTH-1:0] commit_hit;
   logic [DEPTH-1:0] committed_upd;
   logic [DEPTH-1:0] valid_next;
   logic [DEPTH-1:0] committed_next;
   logic [CNT_W-1:0] n_committed;
   logic [PTR_W-1:0] head_next;
   logic [PTR_W-1:0] tail_next;
   logic [CNT_W-1:0] count_next;
   logic             push_ok;
   logic             pop;

   logic [0:0]       state;
   logic [0:0]       state_next;
   logic             req_next;
   logic [31:0]      addr_next;
   logic [31:0]      data_next;
   logic [1:0]       size_next;

   // Low address bits never matter for the word-granular hazard compare
   logic [1:0]       unused_ld_low;
   assign unused_ld_low = ld_addr_in[1:0];

   // Status outputs straight from register state
   always_comb begin
      full_out   = (count == CNT_W'(DEPTH));
      idle_out   = (count == '0) && (state == IDLE);
      hazard_out = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i] && (ent[i].addr[31:2] == ld_addr_in[31:2])) begin
            hazard_out = 1'b1;
         end
      end
   end

   // Commit matching and committed-prefix length (commit lands before any truncation)
   always_comb begin
      commit_hit  = '0;
      n_committed = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         commit_hit[i] = commit_lsb_signal_in && valid[i] && !committed[i] &&
                         (ent[i].tag == commit_tag_in);
      end
      committed_upd = committed | commit_hit;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         n_committed = n_committed + CNT_W'(valid[i] && committed_upd[i]);
      end
   end

   // Full is judged before the pop, so a push into a full queue is dropped even on a pop cycle
   assign push_ok = push_in && !full_out && !rollback_in;
   assign pop     = (state == WAIT_MEM) && mem_done_in;

   // Next pointer, count and per-entry flag state
   always_comb begin
      valid_next     = valid;
      committed_next = committed_upd;
      head_next      = head;
      tail_next      = tail;
      count_next     = count;

      if (rollback_in) begin
         valid_next     = valid & committed_upd;
         committed_next = committed_upd & valid_next;
      end
      if (pop) begin
         valid_next[head]     = 1'b0;
         committed_next[head] = 1'b0;
         head_next            = head + PTR_W'(1);
      end
      if (push_ok) begin
         valid_next[tail]     = 1'b1;
         committed_next[tail] = 1'b0;
      end

      // Truncated tail counts from the pre-pop head, which the in-flight entry still occupies
      if (rollback_in) begin
         tail_next  = head + PTR_W'(n_committed);
         count_next = n_committed - CNT_W'(pop);
      end else begin
         tail_next  = push_ok ? tail + PTR_W'(1) : tail;
         count_next = count + CNT_W'(push_ok) - CNT_W'(pop);
      end
   end

   // Queue state
   always_ff @(posedge clk) begin
      if (rst) begin
         valid     <= '0;
         committed <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         valid     <= valid_next;
         committed <= committed_next;
         head      <= head_next;
         tail      <= tail_next;
         count     <= count_next;
      end
   end

   // Entry payload storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent[i] <= '0;
         end
      end else if (push_ok) begin
         ent[tail] <= '{tag:  push_tag_in,
                        addr: push_addr_in,
                        data: push_data_in,
                        size: push_size_in};
      end
   end

   // Drain FSM: next state and next registered memory interface
   always_comb begin
      state_next = state;
      req_next   = mem_req_out;
      addr_next  = mem_addr_out;
      data_next  = mem_data_out;
      size_next  = mem_size_out;

      case (state)
         IDLE: begin
            if (valid[head] && committed[head]) begin
               req_next   = 1'b1;
               addr_next  = ent[head].addr;
               data_next  = ent[head].data;
               size_next  = ent[head].size;
               state_next = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (mem_done_in) begin
               req_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            req_next   = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // Drain FSM registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mem_req_out  <= 1'b0;
         mem_addr_out <= '0;
         mem_data_out <= '0;
         mem_size_out <= '0;
      end else begin
         state        <= state_next;
         mem_req_out  <= req_next;
         mem_addr_out <= addr_next;
         mem_data_out <= data_next;
         mem_size_out <= size_next;
      end
   end

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue; expected memory writes are queued at push
// time and compared in order as the queue issues them.
module tb_store_commit_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        rollback_in;
   logic        push_in;
   logic [3:0]  push_tag_in;
   logic [31:0] push_addr_in;
   logic [31:0] push_data_in;
   logic [1:0]  push_size_in;
   logic        commit_lsb_signal_in;
   logic [3:0]  commit_tag_in;
   logic [31:0] ld_addr_in;
   logic        hazard_out;
   logic        full_out;
   logic        idle_out;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic [31:0] mem_data_out;
   logic [1:0]  mem_size_out;
   logic        mem_done_in;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } wr_t;

   wr_t sb[$];
   int  checks = 0;
   int  errors = 0;

   store_commit_queue #(.DEPTH(8), .TAG_WIDTH(4)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .rollback_in          (rollback_in),
      .push_in              (push_in),
      .push_tag_in          (push_tag_in),
      .push_addr_in         (push_addr_in),
      .push_data_in         (push_data_in),
      .push_size_in         (push_size_in),
      .commit_lsb_signal_in (commit_lsb_signal_in),
      .commit_tag_in        (commit_tag_in),
      .ld_addr_in           (ld_addr_in),
      .hazard_out           (hazard_out),
      .full_out             (full_out),
      .idle_out             (idle_out),
      .mem_req_out          (mem_req_out),
      .mem_addr_out         (mem_addr_out),
      .mem_data_out         (mem_data_out),
      .mem_size_out         (mem_size_out),
      .mem_done_in          (mem_done_in)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] tag, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input bit accept);
      push_in      = 1'b1;
      push_tag_in  = tag;
      push_addr_in = addr;
      push_data_in = data;
      push_size_in = size;
      step();
      push_in = 1'b0;
      if (accept) sb.push_back('{addr: addr, data: data, size: size});
   endtask

   task automatic commit(input logic [3:0] tag);
      commit_lsb_signal_in = 1'b1;
      commit_tag_in        = tag;
      step();
      commit_lsb_signal_in = 1'b0;
   endtask

   // Wait (bounded) for a request and compare it against the oldest expected write
   task automatic wait_req_check(output wr_t exp);
      int n = 0;
      while (mem_req_out !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("req_seen", 32'(mem_req_out), 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("req_addr", mem_addr_out, exp.addr);
      chk("req_data", mem_data_out, exp.data);
      chk("req_size", 32'(mem_size_out), 32'(exp.size));
   endtask

   task automatic service(input int hold);
      wr_t exp;
      wait_req_check(exp);
      if (mem_req_out === 1'b1) begin
         for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_req", 32'(mem_req_out), 32'd1);
            chk("hold_addr", mem_addr_out, exp.addr);
            chk("hold_data", mem_data_out, exp.data);
         end
         mem_done_in = 1'b1;
         step();
         mem_done_in = 1'b0;
         chk("req_drop", 32'(mem_req_out), 32'd0);
      end
   endtask

   initial begin
      wr_t tmp;
      rst = 1'b1;
      rollback_in = 1'b0;
      push_in = 1'b0;
      push_tag_in = '0;
      push_addr_in = '0;
      push_data_in = '0;
      push_size_in = '0;
      commit_lsb_signal_in = 1'b0;
      commit_tag_in = '0;
      ld_addr_in = '0;
      mem_done_in = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_req", 32'(mem_req_out), 32'd0);
      chk("rst_idle", 32'(idle_out), 32'd1);
      chk("rst_full", 32'(full_out), 32'd0);
      chk("rst_hazard", 32'(hazard_out), 32'd0);
      chk("rst_addr", mem_addr_out, 32'd0);

      // Single store: exact commit-to-request latency
      push(4'd3, 32'h100, 32'hDEADBEEF, 2'b10, 1'b1);
      step();
      step();
      commit(4'd3);
      chk("commit_no_req_yet", 32'(mem_req_out), 32'd0);
      step();
      chk("commit_to_req", 32'(mem_req_out), 32'd1);
      service(3);
      chk("single_idle", 32'(idle_out), 32'd1);

      // Fill, drop on full, drain across the pointer wrap
      for (int i = 1; i <= 8; i++)
         push(4'(i), 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 2'(i % 3), 1'b1);
      chk("full_set", 32'(full_out), 32'd1);
      push(4'd9, 32'h1FFC, 32'hBAD0BAD0, 2'b10, 1'b0);
      chk("full_drop_full", 32'(full_out), 32'd1);
      chk("full_drop_count", 32'(dut.count), 32'd8);
      for (int i = 1; i <= 8; i++) commit(4'(i));
      for (int i = 1; i <= 8; i++) service(1);
      chk("fill_idle", 32'(idle_out), 32'd1);
      for (int i = 1; i <= 4; i++)
         push(4'(i), 32'h2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 2'b01, 1'b1);
      for (int i = 1; i <= 4; i++) commit(4'(i));
      for (int i = 1; i <= 4; i++) service(0);
      chk("wrap_idle", 32'(idle_out), 32'd1);

      // Rollback with tag 1 in flight; same-cycle push is ignored
      for (int i = 1; i <= 5; i++)
         push(4'(i), 32'h3000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 2'b10, (i <= 2));
      commit(4'd1);
      commit(4'd2);
      chk("rb_inflight", 32'(mem_req_out), 32'd1);
      rollback_in  = 1'b1;
      push_in      = 1'b1;
      push_tag_in  = 4'd7;
      push_addr_in = 32'h3FF0;
      step();
      rollback_in = 1'b0;
      push_in     = 1'b0;
      chk("rb_count", 32'(dut.count), 32'd2);
      chk("rb_req_kept", 32'(mem_req_out), 32'd1);
      service(2);
      chk("rb_count_after1", 32'(dut.count), 32'd1);
      service(1);
      chk("rb_idle", 32'(idle_out), 32'd1);

      // Push, commit and pop in the same cycle
      push(4'd4, 32'h4000, 32'h4444_4444, 2'b10, 1'b1);
      push(4'd5, 32'h4004, 32'h5555_5555, 2'b00, 1'b1);
      commit(4'd4);
      wait_req_check(tmp);
      push_in              = 1'b1;
      push_tag_in          = 4'd6;
      push_addr_in         = 32'h4008;
      push_data_in         = 32'h6666_6666;
      push_size_in         = 2'b01;
      commit_lsb_signal_in = 1'b1;
      commit_tag_in        = 4'd5;
      mem_done_in          = 1'b1;
      step();
      push_in              = 1'b0;
      commit_lsb_signal_in = 1'b0;
      mem_done_in          = 1'b0;
      sb.push_back('{addr: 32'h4008, data: 32'h6666_6666, size: 2'b01});
      chk("sim_count", 32'(dut.count), 32'd2);
      chk("sim_req_drop", 32'(mem_req_out), 32'd0);
      step();
      chk("sim_next_req", 32'(mem_req_out), 32'd1);
      service(1);
      commit(4'd6);
      service(1);
      chk("sim_idle", 32'(idle_out), 32'd1);

      // Word-granular load hazard
      push(4'd1, 32'h204, 32'h1234_5678, 2'b10, 1'b1);
      ld_addr_in = 32'h206;
      #1;
      chk("haz_same_word", 32'(hazard_out), 32'd1);
      ld_addr_in = 32'h208;
      #1;
      chk("haz_next_word", 32'(hazard_out), 32'd0);
      commit(4'd1);
      service(0);
      ld_addr_in = 32'h206;
      #1;
      chk("haz_drained", 32'(hazard_out), 32'd0);

      // Reset while a write is in flight; late done is ignored
      push(4'd2, 32'h500, 32'h0BAD_F00D, 2'b10, 1'b1);
      commit(4'd2);
      wait_req_check(tmp);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_req", 32'(mem_req_out), 32'd0);
      chk("rstw_idle", 32'(idle_out), 32'd1);
      chk("rstw_addr", mem_addr_out, 32'd0);
      chk("rstw_hazard", 32'(hazard_out), 32'd0);
      mem_done_in = 1'b1;
      step();
      mem_done_in = 1'b0;
      chk("late_done_req", 32'(mem_req_out), 32'd0);
      chk("late_done_idle", 32'(idle_out), 32'd1);
      chk("late_done_count", 32'(dut.count), 32'd0);
      chk("sb_leftover", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
